// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: registers one request, issues a single 8-byte-aligned
// memory access, then returns the lane-extracted and extended load result.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        men,
  output logic        mwen,
  output logic [63:0] raddr,
  output logic [63:0] waddr,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  input  logic [63:0] rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        wen_q, unsigned_q, misalign_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q, wdata_q, result_q;
  logic [2:0]  off;
  logic [63:0] aligned_addr, shifted, load_ext;
  logic [7:0]  store_mask;
  logic        req_misalign;

  assign off          = addr_q[2:0];
  assign aligned_addr = {addr_q[63:3], 3'b000};

  // Alignment is judged on the live request so the first state transition can skip memory.
  always_comb begin
    case (req_size)
      2'd0:    req_misalign = 1'b0;
      2'd1:    req_misalign = req_addr[0];
      2'd2:    req_misalign = |req_addr[1:0];
      default: req_misalign = |req_addr[2:0];
    endcase
  end

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    store_mask = 8'h01 << off;
      2'd1:    store_mask = 8'h03 << off;
      2'd2:    store_mask = 8'h0F << off;
      default: store_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q      <= 1'b0;
      unsigned_q <= 1'b0;
      misalign_q <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      result_q   <= 64'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        wen_q      <= req_wen;
        unsigned_q <= req_unsigned;
        misalign_q <= req_misalign;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        result_q   <= 64'd0;
      end
      // Read data is only valid during the access cycle, so capture it here.
      if (state == ACCESS && !wen_q) result_q <= load_ext;
    end
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    men           = 1'b0;
    mwen          = 1'b0;
    raddr         = 64'd0;
    waddr         = 64'd0;
    wdata         = 64'd0;
    wmask         = 8'd0;
    resp_valid    = 1'b0;
    resp_rdata    = 64'd0;
    resp_misalign = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        men   = 1'b1;
        raddr = aligned_addr;
        waddr = aligned_addr;
        if (wen_q) begin
          mwen  = 1'b1;
          wmask = store_mask;
          wdata = wdata_q << {off, 3'b000};
        end
        state_next = RESP;
      end
      RESP: begin
        resp_valid    = 1'b1;
        resp_rdata    = result_q;
        resp_misalign = misalign_q;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, hand-written multi-cycle
// sequences, and random traffic checked against a byte-level memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        men, mwen;
  logic [63:0] raddr, waddr, wdata, rdata;
  logic [7:0]  wmask;
  logic        resp_valid, resp_ready, resp_misalign;
  logic [63:0] resp_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .men(men), .mwen(mwen), .raddr(raddr), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .rdata(rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign)
  );

  // Simulated memory: 16 doublewords at 0x80000000, with a backdoor preload port.
  logic [63:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [63:0] pre_data = 64'd0;

  assign rdata = (men && !mwen) ? mem[raddr[6:3]] : 64'd0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (men && mwen)
      for (int b = 0; b < 8; b++)
        if (wmask[b]) mem[waddr[6:3]][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Tracks every men cycle and the longest consecutive run of men.
  int men_total = 0, men_run = 0, men_max = 0;
  always @(negedge clk) begin
    if (men) begin
      men_total = men_total + 1;
      men_run   = men_run + 1;
      if (men_run > men_max) men_max = men_run;
    end else begin
      men_run = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int checks = 0, errors = 0;
  logic [63:0] ref_mem [16];

  logic        obs_ready, obs_mis, obs_unstable;
  int          obs_lat, obs_men, obs_mwen;
  logic [63:0] obs_raddr, obs_waddr, obs_wdata, obs_rdata;
  logic [7:0]  obs_wmask;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] exp_rdata;
    logic        exp_mis;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] modelLoad(input logic [63:0] word, input logic [63:0] addr,
                                            input logic [1:0] size, input logic uns);
    int n, off;
    logic [63:0] v;
    n = 1 << size;
    off = int'(addr[2:0]);
    v = 64'd0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = word[8*(off+b) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] modelMask(input logic [63:0] addr, input logic [1:0] size);
    logic [7:0] m;
    m = 8'd0;
    for (int b = 0; b < (1 << size); b++) m[int'(addr[2:0]) + b] = 1'b1;
    return m;
  endfunction

  task automatic modelStore(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wd);
    int off;
    off = int'(addr[2:0]);
    for (int b = 0; b < (1 << size); b++) ref_mem[addr[6:3]][8*(off+b) +: 8] = wd[8*b +: 8];
  endtask

  task automatic preload(input int idx, input logic [63:0] d);
    pre_idx  = 4'(idx);
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Runs one full request/response handshake, starting and ending just after a posedge in IDLE.
  task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                               input logic [1:0] size, input logic uns, input int delay);
    int  m0;
    bit  got;
    m0 = men_total;
    obs_lat = -1; obs_mwen = 0; obs_unstable = 1'b0;
    obs_raddr = 64'd0; obs_waddr = 64'd0; obs_wdata = 64'd0; obs_wmask = 8'd0;
    obs_rdata = 64'd0; obs_mis = 1'b0;
    req_wen = wen; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    @(negedge clk);
    obs_ready = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_ready = (delay == 0);
    got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (men) begin
        obs_raddr = raddr; obs_waddr = waddr; obs_wmask = wmask; obs_wdata = wdata;
        if (mwen) obs_mwen++;
      end
      if (resp_valid) begin
        got = 1'b1; obs_lat = c; obs_rdata = resp_rdata; obs_mis = resp_misalign;
      end
    end
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== obs_rdata || resp_misalign !== obs_mis ||
          req_ready !== 1'b0)
        obs_unstable = 1'b1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    obs_men = men_total - m0;
  endtask

  task automatic runCheck(input string tag, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [1:0] size, input logic uns,
                          input int delay, input logic [63:0] exp_rdata, input logic exp_mis,
                          input logic [7:0] exp_wmask, input logic [63:0] exp_wdata);
    logic [63:0] exp_addr;
    exp_addr = exp_mis ? 64'd0 : {addr[63:3], 3'b000};
    applyStimulus(wen, addr, wd, size, uns, delay);
    checkOutput({tag, ".req_ready"},     64'(obs_ready), 64'd1);
    checkOutput({tag, ".latency"},       64'(obs_lat), exp_mis ? 64'd1 : 64'd2);
    checkOutput({tag, ".men_pulses"},    64'(obs_men), exp_mis ? 64'd0 : 64'd1);
    checkOutput({tag, ".mwen_cycles"},   64'(obs_mwen), (wen && !exp_mis) ? 64'd1 : 64'd0);
    checkOutput({tag, ".raddr"},         obs_raddr, exp_addr);
    checkOutput({tag, ".waddr"},         obs_waddr, exp_addr);
    checkOutput({tag, ".wmask"},         64'(obs_wmask), 64'(exp_wmask));
    checkOutput({tag, ".wdata"},         obs_wdata, exp_wdata);
    checkOutput({tag, ".resp_rdata"},    obs_rdata, exp_rdata);
    checkOutput({tag, ".resp_misalign"}, 64'(obs_mis), 64'(exp_mis));
    checkOutput({tag, ".resp_stable"},   64'(obs_unstable), 64'd0);
    if (wen && !exp_mis) modelStore(addr, size, wd);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".req_ready"},     64'(req_ready), 64'd1);
    checkOutput({tag, ".men"},           64'(men), 64'd0);
    checkOutput({tag, ".mwen"},          64'(mwen), 64'd0);
    checkOutput({tag, ".raddr"},         raddr, 64'd0);
    checkOutput({tag, ".waddr"},         waddr, 64'd0);
    checkOutput({tag, ".wdata"},         wdata, 64'd0);
    checkOutput({tag, ".wmask"},         64'(wmask), 64'd0);
    checkOutput({tag, ".resp_valid"},    64'(resp_valid), 64'd0);
    checkOutput({tag, ".resp_rdata"},    resp_rdata, 64'd0);
    checkOutput({tag, ".resp_misalign"}, 64'(resp_misalign), 64'd0);
  endtask

  initial begin
    logic        wen, uns, mis;
    logic [1:0]  size;
    logic [63:0] addr, wd, exp_rd, exp_wd, expd;
    logic [7:0]  exp_wm;
    int          m0, issued, n, quiet;
    bit          accepted, got;
    int          men_cyc[$];
    logic [63:0] resp_q[$];

    vecs[0]  = '{1'b0, 64'h80000001, 64'd0, 2'd0, 1'b0, 64'h77, 1'b0, 8'h00, 64'd0};
    vecs[1]  = '{1'b0, 64'h80000000, 64'd0, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF88, 1'b0, 8'h00, 64'd0};
    vecs[2]  = '{1'b0, 64'h80000000, 64'd0, 2'd0, 1'b1, 64'h88, 1'b0, 8'h00, 64'd0};
    vecs[3]  = '{1'b1, 64'h80000006, 64'hABCD, 2'd1, 1'b0, 64'd0, 1'b0, 8'hC0, 64'hABCD000000000000};
    vecs[4]  = '{1'b0, 64'h80000000, 64'd0, 2'd3, 1'b0, 64'hABCD334455667788, 1'b0, 8'h00, 64'd0};
    vecs[5]  = '{1'b0, 64'h80000004, 64'd0, 2'd2, 1'b0, 64'hFFFFFFFFABCD3344, 1'b0, 8'h00, 64'd0};
    vecs[6]  = '{1'b0, 64'h80000006, 64'd0, 2'd1, 1'b1, 64'hABCD, 1'b0, 8'h00, 64'd0};
    vecs[7]  = '{1'b0, 64'h80000006, 64'd0, 2'd1, 1'b0, 64'hFFFFFFFFFFFFABCD, 1'b0, 8'h00, 64'd0};
    vecs[8]  = '{1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0, 64'd0, 1'b1, 8'h00, 64'd0};
    vecs[9]  = '{1'b1, 64'h80000001, 64'h12345, 2'd3, 1'b0, 64'd0, 1'b1, 8'h00, 64'd0};
    vecs[10] = '{1'b1, 64'h80000003, 64'h1FF, 2'd0, 1'b0, 64'd0, 1'b0, 8'h08, 64'h1FF000000};
    vecs[11] = '{1'b0, 64'h80000000, 64'd0, 2'd3, 1'b0, 64'hABCD3344FF667788, 1'b0, 8'h00, 64'd0};
    vecs[12] = '{1'b0, 64'h80000000, 64'd0, 2'd2, 1'b1, 64'hFF667788, 1'b0, 8'h00, 64'd0};

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    preload(0, 64'h1122334455667788);
    for (int i = 1; i < 16; i++) preload(i, {$urandom, $urandom});
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      runCheck($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wd, vecs[i].size,
               vecs[i].uns, 0, vecs[i].exp_rdata, vecs[i].exp_mis, vecs[i].exp_wmask,
               vecs[i].exp_wdata);

    // Backpressure: response held for 5 cycles while a second request waits.
    $display("[TB] backpressure sequence");
    m0 = men_total;
    expd = ref_mem[1];
    req_wen = 1'b0; req_addr = 64'h80000008; req_size = 2'd3; req_unsigned = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_addr = 64'h80000010;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp.hold%0d.resp_valid", k), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("bp.hold%0d.resp_rdata", k), resp_rdata, expd);
      checkOutput($sformatf("bp.hold%0d.req_ready", k), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.idle.req_ready", 64'(req_ready), 64'd1);
    checkOutput("bp.second_not_yet_accepted", 64'(men_total - m0), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        checkOutput("bp.second.resp_rdata", resp_rdata, ref_mem[2]);
      end
    end
    checkOutput("bp.second.resp_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;

    // Reset asserted during the ACCESS cycle of a load.
    $display("[TB] reset during access sequence");
    m0 = men_total;
    req_wen = 1'b0; req_addr = 64'h80000018; req_size = 2'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstacc.men_in_access", 64'(men), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("rstacc");
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) quiet++;
    end
    checkOutput("rstacc.no_resp_valid", 64'(quiet), 64'd0);
    checkOutput("rstacc.men_pulses", 64'(men_total - m0), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back aligned double loads with req_valid held high.
    $display("[TB] back-to-back sequence");
    m0 = men_total; issued = 0;
    req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h80000020;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (men) men_cyc.push_back(cyc);
      if (resp_valid) resp_q.push_back(resp_rdata);
      accepted = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        issued++;
        if (issued == 4) req_valid = 1'b0;
        else req_addr = 64'h80000020 + 64'(8 * issued);
      end
    end
    checkOutput("b2b.men_pulses", 64'(men_total - m0), 64'd4);
    checkOutput("b2b.men_cycles", 64'(men_cyc.size()), 64'd4);
    for (int i = 1; i < men_cyc.size(); i++)
      checkOutput($sformatf("b2b.spacing%0d", i), 64'(men_cyc[i] - men_cyc[i-1]), 64'd3);
    checkOutput("b2b.responses", 64'(resp_q.size()), 64'd4);
    for (int i = 0; i < resp_q.size() && i < 4; i++)
      checkOutput($sformatf("b2b.resp%0d", i), resp_q[i], ref_mem[4+i]);

    // Random traffic against the byte-level model.
    $display("[TB] random sequence");
    for (int i = 0; i < 60; i++) begin
      wen  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = 64'h80000000 + 64'($urandom_range(0, 127));
      wd   = {$urandom, $urandom};
      n    = 1 << size;
      mis  = (int'(addr[2:0]) % n) != 0;
      exp_rd = 64'd0; exp_wm = 8'd0; exp_wd = 64'd0;
      if (!mis) begin
        if (wen) begin
          exp_wm = modelMask(addr, size);
          exp_wd = wd << (8 * int'(addr[2:0]));
        end else begin
          exp_rd = modelLoad(ref_mem[addr[6:3]], addr, size, uns);
        end
      end
      runCheck($sformatf("rand%0d", i), wen, addr, wd, size, uns, $urandom_range(0, 3),
               exp_rd, mis, exp_wm, exp_wd);
    end

    checkOutput("men_max_consecutive", 64'(men_max), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
